// File: rtl/next_word_pkg.sv
// next_word_pkg: shared widths and FSM state type for the next-word unpacker
package next_word_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_BYTE_W = 8;
  localparam int BYTES_PER_WORD = DEF_DATA_W / DEF_BYTE_W;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/next_word_fifo.sv
// next_word_fifo: synchronous DEPTH x DW word FIFO with count-based full/empty
module next_word_fifo #(
  parameter int DW = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  // storage array, no reset needed since count gates every read
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
endmodule

// File: rtl/next_word_unpacker.sv
// next_word_unpacker: buffers words and emits them LSB byte first; NEXT_WORD_CHECK_EN adds an EXPECT compare
module next_word_unpacker import next_word_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int DEPTH = 4,
  parameter logic [DATA_W-1:0] EXPECT = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] next_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic [15:0]       word_cnt,
  output logic              err
);
  localparam int NB = DATA_W / BYTE_W;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  state_t state;
  logic [DATA_W-1:0] shift, fifo_dout;
  logic [IW-1:0] idx;
  logic full, empty, pop, last;
  logic [$clog2(DEPTH):0] unused_count;
  next_word_fifo #(.DW(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(in_valid && !full), .din(next_in), .pop(pop),
    .dout(fifo_dout), .full(full), .empty(empty), .count(unused_count)
  );
  assign in_ready = !full;
  assign last = idx == IW'(NB-1);
  assign pop = !empty && (state == IDLE || (out_ready && last));
  assign out_valid = state == SHIFT;
  assign out_data = out_valid ? shift[BYTE_W-1:0] : '0;
  assign out_last = out_valid && last;
  // pop loads a fresh word (also zero-bubble on the last byte); otherwise shift on each accepted byte
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      idx <= '0;
      word_cnt <= '0;
    end else if (pop) begin
      state <= SHIFT;
      shift <= fifo_dout;
      idx <= '0;
      word_cnt <= word_cnt + 16'd1;
    end else if (state == SHIFT && out_ready) begin
      if (last) state <= IDLE;
      shift <= shift >> BYTE_W;
      idx <= idx + 1'b1;
    end
`ifdef NEXT_WORD_CHECK_EN
  // sticky flag raised the cycle after a popped word differs from EXPECT
  always_ff @(posedge clk)
    if (rst) err <= 1'b0;
    else if (pop && fifo_dout != EXPECT) err <= 1'b1;
`else
  logic unused_expect;
  assign unused_expect = ^EXPECT;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_next_word_unpacker.sv
// tb_next_word_unpacker: directed and random checks against a byte-queue model
module tb_next_word_unpacker;
`ifdef NEXT_WORD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_last, err;
  logic [63:0] next_in = '0;
  logic [7:0] out_data;
  logic [15:0] word_cnt;
  int n_cmp = 0, n_bad = 0, accepted = 0, cyc = 0;
  logic [7:0] exp_q[$];
  bit last_q[$];
  bit hold_pend = 0, hold_last = 0;
  logic [7:0] hold_data = '0;

  next_word_unpacker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .next_in(next_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .word_cnt(word_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (hold_pend) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_data);
      chk("hold_last", out_last, hold_last);
    end
    hold_pend = !rst && out_valid && !out_ready;
    hold_data = out_data;
    hold_last = out_last;
    if (!rst && in_valid && in_ready) begin
      for (int b = 0; b < 8; b++) begin
        exp_q.push_back(next_in[8*b +: 8]);
        last_q.push_back(b == 7);
      end
      accepted++;
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("byte_unexpected", out_valid, 0);
      else begin
        chk("byte", out_data, exp_q.pop_front());
        chk("last", out_last, last_q.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int bound, output int n);
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 0;
    out_ready = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    exp_q.delete();
    last_q.delete();
    hold_pend = 0;
  endtask

  initial begin
    @(negedge clk);
    // 1: reset
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_err", err, 0);
    // 2: single word, latency N+2, 8 consecutive bytes
    out_ready = 1;
    in_valid = 1;
    next_in = 64'h0807060504030201;
    tick();
    in_valid = 0;
    chk("t2_lat_n1", out_valid, 0);
    tick();
    chk("t2_lat_n2", out_valid, 1);
    chk("t2_first", out_data, 8'h01);
    drain(20, cyc);
    chk("t2_cycles", cyc, 8);
    chk("t2_word_cnt", word_cnt, 1);
    // 3: stall, back-to-back pushes until full, then bubble-free drain
    out_ready = 0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      next_in = {$urandom, $urandom};
      tick();
    end
    in_valid = 0;
    chk("t3_in_ready", in_ready, 0);
    chk("t3_accepted", accepted, 5);
    out_ready = 1;
    drain(100, cyc);
    chk("t3_cycles", cyc, 40);
    chk("t3_word_cnt", word_cnt, 6);
    // 4: toggling out_ready during a word
    out_ready = 0;
    in_valid = 1;
    next_in = 64'hA1B2C3D4E5F60718;
    tick();
    in_valid = 0;
    tick();
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 2 == 0);
      tick();
    end
    out_ready = 1;
    drain(20, cyc);
    chk("t4_word_cnt", word_cnt, 7);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid = $urandom_range(1, 0) == 1;
      out_ready = $urandom_range(3, 0) != 0;
      next_in = {$urandom, $urandom};
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    drain(400, cyc);
    // 5: checker
    do_reset();
    chk("t5_err_rst", err, 0);
    out_ready = 1;
    in_valid = 1;
    next_in = 64'h1;
    tick();
    in_valid = 0;
    drain(20, cyc);
    chk("t5_err_match", err, 0);
    in_valid = 1;
    next_in = 64'h2;
    tick();
    in_valid = 0;
    drain(20, cyc);
    chk("t5_err_mismatch", err, CHK);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_err_sticky", err, CHK);
    // 6: reset mid-word with two words queued
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      next_in = {$urandom, $urandom};
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    do_reset();
    out_ready = 1;
    chk("t6_err", err, 0);
    chk("t6_word_cnt", word_cnt, 0);
    chk("t6_in_ready", in_ready, 1);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) cyc++;
      tick();
    end
    chk("t6_no_valid", cyc, 0);
    // word_cnt wrap
    force dut.word_cnt = 16'hFFFF;
    tick();
    release dut.word_cnt;
    in_valid = 1;
    next_in = 64'h1122334455667788;
    tick();
    in_valid = 0;
    tick();
    chk("t6_wrap", word_cnt, 0);
    drain(20, cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
